// File: rtl/alu_mdu.sv
// Integer ALU with an iterative-latency multiply/divide unit and HI/LO registers.
// The ALU is purely combinational; mult/div results land in HI/LO when busy drops.
module alu_mdu #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [$clog2(WIDTH)-1:0]   shamt,
    input  logic [4:0]                 alu_op,
    input  logic                       ovf_chk,
    output logic [WIDTH-1:0]           result,
    output logic                       ovf_exc,
    input  logic [2:0]                 md_op,
    input  logic                       md_start,
    input  logic                       md_cancel,
    output logic                       busy,
    output logic [WIDTH-1:0]           hi,
    output logic [WIDTH-1:0]           lo
);

    localparam int unsigned SW   = $clog2(WIDTH);
    localparam int unsigned MaxC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MaxC + 1);
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    // ---------------- ALU ----------------
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SW-1:0]    w_vsh;
    logic             w_ovf;

    assign w_sum  = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign w_diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    assign w_vsh  = a[SW-1:0];

    always_comb begin
        result = '0;
        w_ovf  = 1'b0;
        case (alu_op)
            5'd0: begin
                result = w_sum[WIDTH-1:0];
                w_ovf  = w_sum[WIDTH] ^ w_sum[WIDTH-1];
            end
            5'd1: begin
                result = w_diff[WIDTH-1:0];
                w_ovf  = w_diff[WIDTH] ^ w_diff[WIDTH-1];
            end
            5'd2:  result = a | b;
            5'd3:  result = a & b;
            5'd4:  result = a ^ b;
            5'd5:  result = ~(a | b);
            5'd6:  result = b << shamt;
            5'd7:  result = b >> shamt;
            5'd8:  result = $signed(b) >>> shamt;
            5'd9:  result = b << w_vsh;
            5'd10: result = b >> w_vsh;
            5'd11: result = $signed(b) >>> w_vsh;
            5'd12: result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            5'd13: result = {{(WIDTH-1){1'b0}}, a < b};
            5'd14: result = b << (WIDTH / 2);
            default: result = '0;
        endcase
    end

    assign ovf_exc = ovf_chk & w_ovf;

    // ---------------- MDU ----------------
    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] w_hi_n;
    logic [WIDTH-1:0] w_lo_n;

    // Result is evaluated from the latched operands; only sampled on the final busy cycle.
    always_comb begin
        w_hi_n = r_hi;
        w_lo_n = r_lo;
        case (r_op)
            2'd0: {w_hi_n, w_lo_n} = $signed({{WIDTH{r_a[WIDTH-1]}}, r_a})
                                   * $signed({{WIDTH{r_b[WIDTH-1]}}, r_b});
            2'd1: {w_hi_n, w_lo_n} = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
            2'd2: begin
                if (r_b == '0) begin
                    w_lo_n = '1;
                    w_hi_n = r_a;
                end else if (r_a == MinNeg && r_b == '1) begin
                    w_lo_n = MinNeg;
                    w_hi_n = '0;
                end else begin
                    w_lo_n = $signed(r_a) / $signed(r_b);
                    w_hi_n = $signed(r_a) % $signed(r_b);
                end
            end
            default: begin
                if (r_b == '0) begin
                    w_lo_n = '1;
                    w_hi_n = r_a;
                end else begin
                    w_lo_n = r_a / r_b;
                    w_hi_n = r_a % r_b;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else if (r_busy) begin
            // Any md_start seen while busy, including the last cycle, is dropped.
            if (md_cancel) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else if (r_cnt == '0) begin
                r_busy <= 1'b0;
                r_hi   <= w_hi_n;
                r_lo   <= w_lo_n;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end else if (md_start) begin
            case (md_op)
                3'd0, 3'd1: begin
                    r_a    <= a;
                    r_b    <= b;
                    r_op   <= md_op[1:0];
                    r_busy <= 1'b1;
                    r_cnt  <= CW'(MUL_CYCLES - 1);
                end
                3'd2, 3'd3: begin
                    r_a    <= a;
                    r_b    <= b;
                    r_op   <= md_op[1:0];
                    r_busy <= 1'b1;
                    r_cnt  <= CW'(DIV_CYCLES - 1);
                end
                3'd4:    r_hi <= a;
                3'd5:    r_lo <= a;
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: random ALU/MDU traffic against an arithmetic reference
// model, plus directed cancel, restart, reset and 16-bit corner cases.
module tb_alu_mdu;

    localparam longint SMAX = 64'sh7FFF_FFFF;
    localparam longint SMIN = -SMAX - 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] a, b, result, hi, lo;
    logic [4:0]  shamt, alu_op;
    logic        ovf_chk, ovf_exc, md_start, md_cancel, busy;
    logic [2:0]  md_op;

    logic [15:0] a16, b16, result16, hi16, lo16;
    logic [3:0]  shamt16;
    logic [4:0]  alu_op16;
    logic        ovf_chk16, ovf_exc16, md_start16, md_cancel16, busy16;
    logic [2:0]  md_op16;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) u_dut (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .shamt(shamt), .alu_op(alu_op),
        .ovf_chk(ovf_chk), .result(result), .ovf_exc(ovf_exc), .md_op(md_op),
        .md_start(md_start), .md_cancel(md_cancel), .busy(busy), .hi(hi), .lo(lo)
    );

    alu_mdu #(.WIDTH(16), .MUL_CYCLES(3), .DIV_CYCLES(4)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .a(a16), .b(b16), .shamt(shamt16), .alu_op(alu_op16),
        .ovf_chk(ovf_chk16), .result(result16), .ovf_exc(ovf_exc16), .md_op(md_op16),
        .md_start(md_start16), .md_cancel(md_cancel16), .busy(busy16), .hi(hi16), .lo(lo16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Reference ALU: {ovf_exc, result}, worked in 64-bit integer arithmetic.
    function automatic logic [32:0] alu_ref(input logic [4:0] op, input logic [31:0] ia,
                                            input logic [31:0] ib, input logic [4:0] sh,
                                            input logic chk);
        longint sa, sb, s;
        logic [31:0] r;
        logic ov;
        int vs;
        sa = longint'($signed(ia));
        sb = longint'($signed(ib));
        s  = 0;
        r  = '0;
        ov = 1'b0;
        vs = int'(ia % 32);
        case (op)
            5'd0:  begin s = sa + sb; r = s[31:0]; ov = (s > SMAX) || (s < SMIN); end
            5'd1:  begin s = sa - sb; r = s[31:0]; ov = (s > SMAX) || (s < SMIN); end
            5'd2:  r = ia | ib;
            5'd3:  r = ia & ib;
            5'd4:  r = ia ^ ib;
            5'd5:  r = ~(ia | ib);
            5'd6:  r = ib << sh;
            5'd7:  r = ib >> sh;
            5'd8:  r = 32'(sb >>> sh);
            5'd9:  r = ib << vs;
            5'd10: r = ib >> vs;
            5'd11: r = 32'(sb >>> vs);
            5'd12: r = (sa < sb) ? 32'd1 : 32'd0;
            5'd13: r = (ia < ib) ? 32'd1 : 32'd0;
            5'd14: r = 32'(longint'(ib) * 65536);
            default: r = '0;
        endcase
        return {ov & chk, r};
    endfunction

    function automatic void md_ref(input logic [2:0] op, input logic [31:0] ia,
                                   input logic [31:0] ib, input logic [31:0] hi0,
                                   input logic [31:0] lo0, output logic [31:0] nh,
                                   output logic [31:0] nl);
        longint sa, sb, q, r;
        longint unsigned p;
        sa = longint'($signed(ia));
        sb = longint'($signed(ib));
        nh = hi0;
        nl = lo0;
        case (op)
            3'd0: begin q = sa * sb; {nh, nl} = q; end
            3'd1: begin p = {32'd0, ia} * {32'd0, ib}; {nh, nl} = p; end
            3'd2: begin
                if (ib == 0) begin nl = '1; nh = ia; end
                else begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; end
            end
            3'd3: begin
                if (ib == 0) begin nl = '1; nh = ia; end
                else begin nl = ia / ib; nh = ia % ib; end
            end
            3'd4: nh = ia;
            3'd5: nl = ia;
            default: ;
        endcase
    endfunction

    // mode: 0 plain, 1 extra md_start at busy cycle 2, 2 md_start on final busy cycle,
    // 3 md_cancel at busy cycle 4.
    task automatic md_run(input logic [2:0] op, input logic [31:0] ia, input logic [31:0] ib,
                          input int mode);
        logic [31:0] pre_hi, pre_lo, nh, nl;
        int n, exp_n;
        logic held;
        pre_hi = exp_hi;
        pre_lo = exp_lo;
        md_ref(op, ia, ib, exp_hi, exp_lo, nh, nl);
        exp_n = (op < 3'd2) ? 5 : 10;
        a = ia; b = ib; md_op = op; md_start = 1'b1;
        @(posedge clk); #1;
        md_start = 1'b0;
        a = $urandom; b = $urandom;
        n = 0;
        held = 1'b1;
        while (busy && n < 100) begin
            n++;
            if (hi !== pre_hi || lo !== pre_lo) held = 1'b0;
            if (mode == 1 && n == 2) begin md_op = 3'd4; md_start = 1'b1; end
            if (mode == 2 && n == exp_n) begin md_op = 3'd0; md_start = 1'b1; end
            if (mode == 3 && n == 4) md_cancel = 1'b1;
            @(posedge clk); #1;
            md_start = 1'b0;
            md_cancel = 1'b0;
        end
        if (mode == 3) begin nh = pre_hi; nl = pre_lo; exp_n = 4; end
        check($sformatf("md%0d_m%0d_busy_len", op, mode), 64'(n), 64'(exp_n));
        check($sformatf("md%0d_m%0d_held", op, mode), 64'(held), 64'd1);
        check($sformatf("md%0d_m%0d_hi", op, mode), 64'(hi), 64'(nh));
        check($sformatf("md%0d_m%0d_lo", op, mode), 64'(lo), 64'(nl));
        exp_hi = nh;
        exp_lo = nl;
        @(posedge clk); #1;
        check($sformatf("md%0d_m%0d_idle_after", op, mode), 64'(busy), 64'd0);
        check($sformatf("md%0d_m%0d_stable", op, mode), 64'({hi, lo}), {exp_hi, exp_lo});
    endtask

    initial begin
        logic [32:0] ref_v;
        reset_n = 1'b0;
        a = '0; b = '0; shamt = '0; alu_op = '0; ovf_chk = 1'b0;
        md_op = '0; md_start = 1'b0; md_cancel = 1'b0;
        a16 = '0; b16 = '0; shamt16 = '0; alu_op16 = '0; ovf_chk16 = 1'b0;
        md_op16 = '0; md_start16 = 1'b0; md_cancel16 = 1'b0;

        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hilo", 64'({hi, lo}), 64'd0);
        check("rst16_hilo_busy", 64'({busy16, hi16, lo16}), 64'd0);

        // First edge after release must accept an issue.
        md_op = 3'd5; a = 32'hCAFE_F00D; md_start = 1'b1;
        #10 reset_n = 1'b1;
        @(posedge clk); #1;
        md_start = 1'b0;
        exp_lo = 32'hCAFE_F00D;
        check("first_mtlo", 64'(lo), 64'(exp_lo));
        check("first_mtlo_busy", 64'(busy), 64'd0);

        // Random ALU traffic.
        for (int i = 0; i < 60; i++) begin
            alu_op  = 5'($urandom_range(0, 17));
            a       = rnd32();
            b       = rnd32();
            shamt   = 5'($urandom);
            ovf_chk = 1'($urandom);
            #2;
            ref_v = alu_ref(alu_op, a, b, shamt, ovf_chk);
            check($sformatf("alu_op%0d_res", alu_op), 64'(result), 64'(ref_v[31:0]));
            check($sformatf("alu_op%0d_ovf", alu_op), 64'(ovf_exc), 64'(ref_v[32]));
        end

        alu_op = 5'd0; a = 32'h7FFF_FFFF; b = 32'd1; ovf_chk = 1'b1;
        #2;
        check("add_ovf_res", 64'(result), 64'h8000_0000);
        check("add_ovf_exc", 64'(ovf_exc), 64'd1);
        ovf_chk = 1'b0;
        #2;
        check("add_ovf_nochk", 64'(ovf_exc), 64'd0);
        alu_op = 5'd2; ovf_chk = 1'b1;
        #2;
        check("or_no_ovf", 64'(ovf_exc), 64'd0);

        @(posedge clk); #1;
        md_run(3'd0, 32'hFFFF_FFFF, 32'd2, 0);
        check("mult_neg_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_neg_lo", 64'(lo), 64'hFFFF_FFFE);
        md_run(3'd1, 32'hFFFF_FFFF, 32'd2, 0);
        check("multu_hi", 64'(hi), 64'd1);
        md_run(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_m7_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_m7_hi", 64'(hi), 64'hFFFF_FFFF);
        md_run(3'd3, 32'd7, 32'd0, 0);
        check("divu_zero_lo", 64'(lo), 64'hFFFF_FFFF);
        md_run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_minneg_lo", 64'(lo), 64'h8000_0000);
        md_run(3'd2, 32'hFFFF_FFFB, 32'd0, 0);

        for (int i = 0; i < 8; i++) md_run(3'($urandom_range(0, 3)), rnd32(), rnd32(), 0);

        md_run(3'd2, 32'd1000, 32'd7, 3);
        md_run(3'd2, 32'd1000, 32'd7, 1);
        md_run(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 2);
        md_run(3'd1, 32'h0001_0000, 32'h0001_0000, 3);

        // Idle cancel and reserved ops leave everything alone.
        md_cancel = 1'b1;
        @(posedge clk); #1;
        md_cancel = 1'b0;
        check("idle_cancel", 64'({busy, hi, lo}), {31'd0, 1'b0, exp_hi, exp_lo});
        for (int k = 6; k < 8; k++) begin
            md_op = 3'(k); a = 32'hDEAD_BEEF; md_start = 1'b1;
            @(posedge clk); #1;
            md_start = 1'b0;
            check($sformatf("reserved_op%0d", k), 64'({busy, hi, lo}),
                  {31'd0, 1'b0, exp_hi, exp_lo});
        end

        md_op = 3'd4; a = 32'h5555_AAAA; md_start = 1'b1;
        @(posedge clk); #1;
        md_start = 1'b0;
        exp_hi = 32'h5555_AAAA;
        check("mthi", 64'(hi), 64'(exp_hi));

        // Asynchronous reset in the middle of a multiply.
        md_op = 3'd0; a = 32'd3; b = 32'd4; md_start = 1'b1;
        @(posedge clk); #1;
        md_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_hilo", 64'({hi, lo}), 64'd0);
        #3 reset_n = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        repeat (12) @(posedge clk);
        #1;
        check("post_rst_quiet", 64'({busy, hi, lo}), 64'd0);

        // 16-bit instance corners.
        alu_op16 = 5'd11; b16 = 16'h8000; a16 = 16'd4;
        #2;
        check("w16_srav", 64'(result16), 64'hF800);
        alu_op16 = 5'd13; a16 = 16'hFFFF; b16 = 16'd1;
        #2;
        check("w16_sltu", 64'(result16), 64'd0);
        alu_op16 = 5'd12;
        #2;
        check("w16_slt", 64'(result16), 64'd1);
        alu_op16 = 5'd14; b16 = 16'h00AB;
        #2;
        check("w16_lui", 64'(result16), 64'hAB00);
        md_op16 = 3'd4; a16 = 16'h1234; md_start16 = 1'b1;
        @(posedge clk); #1;
        md_start16 = 1'b0;
        check("w16_mthi", 64'(hi16), 64'h1234);
        check("w16_mthi_busy", 64'(busy16), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
